// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with flush, bubble control word and optional 2-entry skid buffer
module pipe_stage_reg #(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 64,
    parameter int                PC_W        = 32,
    parameter int                SKID        = 1,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);
    localparam int W = CTRL_W + DATA_W + PC_W;
    logic         main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d, accept, retire;
    logic [W-1:0] main_q, main_d, skid_q, skid_d, in_word;
    logic [1:0]   occ_q, occ_d;
    assign in_word = {in_ctrl, in_data, in_pc};
    always_comb begin
        in_ready = (SKID != 0) ? rdy_q : (!main_v_q | out_ready);
        accept   = in_valid & in_ready;
        retire   = main_v_q & out_ready;
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        // main refills from skid first to keep FIFO order
        if (!main_v_q || retire) begin
            main_v_d = skid_v_q | accept;
            main_d   = skid_v_q ? skid_q : (accept ? in_word : main_q);
            skid_v_d = 1'b0;
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d   = in_word;
        end
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d   = '0;
        end
        rdy_d = !skid_v_d;
        occ_d = {1'b0, main_v_d} + {1'b0, skid_v_d};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            rdy_q    <= 1'b1;
            occ_q    <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            rdy_q    <= rdy_d;
            occ_q    <= occ_d;
        end
    end
    assign out_valid = main_v_q;
    assign out_ctrl  = main_v_q ? main_q[W-1 -: CTRL_W] : BUBBLE_CTRL;
    assign out_data  = main_q[PC_W +: DATA_W];
    assign out_pc    = main_q[PC_W-1:0];
    assign occupancy = occ_q;
endmodule
